// File: rtl/cpu_32_core.sv
// Multicycle, non-pipelined 32-bit processor: IF/ID/EX/MA/WB, one state per clock.
// Unified word-addressed instruction/data memory; REG/MEM/PC/HALTED/state are
// left as plain named signals so benches can preload and inspect them.
module cpu_32_core #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SUBI  = 6'd9;
  localparam logic [5:0] OP_BEQZ  = 6'd10;
  localparam logic [5:0] OP_BNEQZ = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_HLT   = 6'd63;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MA  = 3'b011,
    S_WB  = 3'b100,
    S_HLT = 3'b101
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] REG [32];
  logic [31:0] MEM [MEM_WORDS];
  logic [31:0] PC;
  logic        HALTED;

  logic [31:0] IR;
  logic [31:0] NPC;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Imm;
  logic [31:0] alu_out;
  logic        cond;
  logic [31:0] lmd;

  logic [5:0]  op_c;
  logic [4:0]  rs_c;
  logic [4:0]  rt_c;
  logic [4:0]  rd_c;
  logic [31:0] alu_c;
  logic        cond_c;
  logic        wr_en_c;
  logic [4:0]  wr_dst_c;
  logic [AW-1:0] ea_c;

  assign op_c   = IR[31:26];
  assign rs_c   = IR[25:21];
  assign rt_c   = IR[20:16];
  assign rd_c   = IR[15:11];
  assign ea_c   = alu_out[AW-1:0];
  assign halted = HALTED;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing; HLT leaves WB for the terminal HLT state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:    state_nxt = S_ID;
      S_ID:    state_nxt = S_EX;
      S_EX:    state_nxt = S_MA;
      S_MA:    state_nxt = S_WB;
      S_WB:    state_nxt = (op_c == OP_HLT) ? S_HLT : S_IF;
      S_HLT:   state_nxt = S_HLT;
      default: state_nxt = S_IF;
    endcase
  end

  // ALU, effective address and branch target/condition
  always_comb begin
    alu_c  = 32'd0;
    cond_c = 1'b0;
    case (op_c)
      OP_ADD:   alu_c = A + B;
      OP_SUB:   alu_c = A - B;
      OP_AND:   alu_c = A & B;
      OP_OR:    alu_c = A | B;
      OP_SLT:   alu_c = 32'($signed(A) < $signed(B));
      OP_MUL:   alu_c = A * B;
      OP_LW,
      OP_SW,
      OP_ADDI:  alu_c = A + Imm;
      OP_SUBI:  alu_c = A - Imm;
      OP_SLTI:  alu_c = 32'($signed(A) < $signed(Imm));
      OP_BEQZ: begin
        alu_c  = NPC + Imm;
        cond_c = (A == 32'd0);
      end
      OP_BNEQZ: begin
        alu_c  = NPC + Imm;
        cond_c = (A != 32'd0);
      end
      default:  alu_c = 32'd0;
    endcase
  end

  // Register write-back destination; R0 writes are dropped here
  always_comb begin
    wr_en_c  = 1'b0;
    wr_dst_c = 5'd0;
    case (op_c)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        wr_en_c  = 1'b1;
        wr_dst_c = rd_c;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        wr_en_c  = 1'b1;
        wr_dst_c = rt_c;
      end
      default: begin
        wr_en_c  = 1'b0;
        wr_dst_c = 5'd0;
      end
    endcase
    if (wr_dst_c == 5'd0) begin
      wr_en_c = 1'b0;
    end
  end

  // Datapath pipeline-stage registers and PC/HALTED update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC      <= 32'd0;
      HALTED  <= 1'b0;
      IR      <= 32'd0;
      NPC     <= 32'd0;
      A       <= 32'd0;
      B       <= 32'd0;
      Imm     <= 32'd0;
      alu_out <= 32'd0;
      cond    <= 1'b0;
      lmd     <= 32'd0;
    end else begin
      case (state)
        S_IF: begin
          IR  <= MEM[PC[AW-1:0]];
          NPC <= PC + 32'd1;
        end
        S_ID: begin
          A   <= (rs_c == 5'd0) ? 32'd0 : REG[rs_c];
          B   <= (rt_c == 5'd0) ? 32'd0 : REG[rt_c];
          Imm <= {{16{IR[15]}}, IR[15:0]};
        end
        S_EX: begin
          alu_out <= alu_c;
          cond    <= cond_c;
        end
        S_MA: begin
          if (op_c == OP_LW) begin
            lmd <= MEM[ea_c];
          end
          PC <= cond ? alu_out : NPC;
        end
        S_WB: begin
          if (op_c == OP_HLT) begin
            HALTED <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Data memory store; gated by rst_n so an aborted instruction never writes
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_MA) && (op_c == OP_SW)) begin
      MEM[ea_c] <= B;
    end
  end

  // Register file write-back; gated by rst_n so an aborted instruction never writes
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_WB) && wr_en_c) begin
      REG[wr_dst_c] <= (op_c == OP_LW) ? lmd : alu_out;
    end
  end

endmodule

// File: tb/tb_cpu_32_core.sv
// Scoreboard bench for cpu_32_core: directed programs preloaded through the
// hierarchy, expectations queued by the stimulus and drained by a monitor.
module tb_cpu_32_core;

  localparam logic [31:0] HLT = 32'hFC000000;

  typedef enum int unsigned {K_REG, K_MEM, K_PC, K_HALT, K_STATE, K_CYC} kind_t;

  typedef struct {
    kind_t       kind;
    int unsigned idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;
  logic chk_req = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  cpu_32_core #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; counts edges where rst_n was sampled high
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic logic [31:0] actual(exp_t e);
    case (e.kind)
      K_REG:   return dut.REG[e.idx];
      K_MEM:   return dut.MEM[e.idx];
      K_PC:    return dut.PC;
      K_HALT:  return {31'd0, halted};
      K_STATE: return {29'd0, dut.state};
      default: return 32'(cyc);
    endcase
  endfunction

  // Monitor: drain scoreboard when the core halts or the stimulus asks for a snapshot
  initial begin
    logic halted_q;
    exp_t e;
    logic [31:0] a;
    halted_q = 1'b0;
    forever begin
      @(negedge clk);
      if ((halted === 1'b1 && halted_q !== 1'b1) || chk_req) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = actual(e);
          checks++;
          if (a === e.val) passes++;
          else $display("FAIL %s: got %h expected %h", e.name, a, e.val);
        end
      end
      halted_q = halted;
    end
  end

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push(kind_t k, int unsigned idx, logic [31:0] v, string name);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Hold reset and reload memory/registers; returns 2 time units after a reset edge
  task automatic reset_and_load();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 1024; i++) dut.MEM[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.REG[k] = 32'(k);
  endtask

  // Wait (bounded) for the monitor to consume every queued expectation
  task automatic wait_drain(int budget, string tag);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      $display("FAIL %s/%s: timed out, expected %h never checked", tag, e.name, e.val);
    end
  endtask

  task automatic snapshot(string tag);
    chk_req = 1'b1;
    wait_drain(5, tag);
    chk_req = 1'b0;
  endtask

  task automatic run(string tag);
    rst_n = 1'b1;
    wait_drain(200, tag);
    #2;
  endtask

  initial begin
    // Reset state and ADD + HLT
    reset_and_load();
    dut.MEM[0] = 32'h00222000;
    dut.MEM[1] = HLT;
    push(K_PC, 0, 32'd0, "rst_pc");
    push(K_HALT, 0, 32'd0, "rst_halted");
    push(K_STATE, 0, 32'd0, "rst_state");
    snapshot("reset");
    #2;
    push(K_REG, 4, 32'd3, "add_r4");
    push(K_PC, 0, 32'd2, "add_pc");
    push(K_CYC, 0, 32'd10, "add_cycles");
    push(K_STATE, 0, 32'd5, "add_state_hlt");
    run("add");
    checks++;
    if (halted === 1'b1) passes++;
    else $display("FAIL add_direct_halted: got %b expected 1", halted);
    checks++;
    if (dut.REG[4] === 32'd3) passes++;
    else $display("FAIL add_direct_r4: got %h expected 3", dut.REG[4]);

    // SUB then ADDI with negative immediate
    reset_and_load();
    dut.MEM[0] = 32'h04413800;
    dut.MEM[1] = 32'h2021FFFF;
    dut.MEM[2] = HLT;
    push(K_REG, 7, 32'd1, "sub_r7");
    push(K_REG, 1, 32'd0, "addi_r1");
    push(K_CYC, 0, 32'd15, "sub_cycles");
    run("sub");

    // LW then SW
    reset_and_load();
    dut.MEM[8] = 32'd4;
    dut.MEM[0] = 32'h19020000;
    dut.MEM[1] = 32'h1CA20002;
    dut.MEM[2] = HLT;
    push(K_REG, 2, 32'd4, "lw_r2");
    push(K_MEM, 7, 32'd4, "sw_mem7");
    push(K_PC, 0, 32'd3, "lwsw_pc");
    run("lwsw");
    checks++;
    if (dut.MEM[7] === 32'd4) passes++;
    else $display("FAIL lwsw_direct_mem7: got %h expected 4", dut.MEM[7]);

    // BEQZ R0 taken skips ADDI
    reset_and_load();
    dut.MEM[0] = 32'h28000001;
    dut.MEM[1] = 32'h20210005;
    dut.MEM[2] = HLT;
    push(K_REG, 1, 32'd1, "beqz_r1");
    push(K_CYC, 0, 32'd10, "beqz_cycles");
    push(K_PC, 0, 32'd3, "beqz_pc");
    run("beqz");

    // BNEQZ R1 taken skips ADDI
    reset_and_load();
    dut.MEM[0] = 32'h2C200001;
    dut.MEM[1] = 32'h20210005;
    dut.MEM[2] = HLT;
    push(K_REG, 1, 32'd1, "bneqz_r1");
    push(K_CYC, 0, 32'd10, "bneqz_cycles");
    run("bneqz");

    // Reset asserted during EX of ADD R4 aborts it, then program reruns
    reset_and_load();
    dut.MEM[0] = 32'h00222000;
    dut.MEM[1] = HLT;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    push(K_REG, 4, 32'd4, "abort_r4");
    push(K_PC, 0, 32'd0, "abort_pc");
    push(K_STATE, 0, 32'd0, "abort_state");
    push(K_HALT, 0, 32'd0, "abort_halted");
    snapshot("abort");
    #2;
    push(K_REG, 4, 32'd3, "rerun_r4");
    push(K_PC, 0, 32'd2, "rerun_pc");
    push(K_CYC, 0, 32'd10, "rerun_cycles");
    run("rerun");

    // Write to R0 ignored; halted core stays frozen
    reset_and_load();
    dut.MEM[0] = 32'h20200005;
    dut.MEM[1] = HLT;
    push(K_REG, 0, 32'd0, "r0_zero");
    push(K_PC, 0, 32'd2, "r0_pc");
    run("r0");
    repeat (20) @(posedge clk);
    #2;
    push(K_PC, 0, 32'd2, "frozen_pc");
    push(K_REG, 0, 32'd0, "frozen_r0");
    push(K_REG, 1, 32'd1, "frozen_r1");
    push(K_MEM, 0, 32'h20200005, "frozen_mem0");
    push(K_STATE, 0, 32'd5, "frozen_state");
    push(K_HALT, 0, 32'd1, "frozen_halted");
    snapshot("frozen");
    checks++;
    if (dut.PC === 32'd2) passes++;
    else $display("FAIL frozen_direct_pc: got %h expected 2", dut.PC);

    // Mixed ALU ops, signed compares, NOP opcode, address wrap, untaken branch
    reset_and_load();
    dut.MEM[0]    = enc_i(6'd9,  5'd0,  5'd20, 16'd5);
    dut.MEM[1]    = enc_r(6'd2,  5'd3,  5'd6,  5'd10);
    dut.MEM[2]    = enc_r(6'd3,  5'd3,  5'd6,  5'd11);
    dut.MEM[3]    = enc_r(6'd4,  5'd20, 5'd3,  5'd12);
    dut.MEM[4]    = enc_r(6'd4,  5'd3,  5'd20, 5'd14);
    dut.MEM[5]    = enc_r(6'd5,  5'd20, 5'd7,  5'd15);
    dut.MEM[6]    = enc_i(6'd12, 5'd20, 5'd16, 16'hFFFC);
    dut.MEM[7]    = enc_i(6'd12, 5'd3,  5'd17, 16'd2);
    dut.MEM[8]    = enc_i(6'd20, 5'd0,  5'd18, 16'h1234);
    dut.MEM[9]    = enc_i(6'd6,  5'd20, 5'd19, 16'd0);
    dut.MEM[10]   = enc_i(6'd7,  5'd22, 5'd9,  16'h7FFF);
    dut.MEM[11]   = enc_i(6'd10, 5'd3,  5'd0,  16'd5);
    dut.MEM[12]   = enc_r(6'd1,  5'd0,  5'd1,  5'd24);
    dut.MEM[13]   = HLT;
    dut.MEM[1019] = 32'h12345678;
    push(K_REG, 20, 32'hFFFFFFFB, "subi_r20");
    push(K_REG, 10, 32'd2, "and_r10");
    push(K_REG, 11, 32'd7, "or_r11");
    push(K_REG, 12, 32'd1, "slt_neg_r12");
    push(K_REG, 14, 32'd0, "slt_pos_r14");
    push(K_REG, 15, 32'hFFFFFFDD, "mul_r15");
    push(K_REG, 16, 32'd1, "slti_r16");
    push(K_REG, 17, 32'd0, "slti_r17");
    push(K_REG, 18, 32'd18, "nop_r18");
    push(K_REG, 19, 32'h12345678, "lw_wrap_r19");
    push(K_MEM, 21, 32'd9, "sw_wrap_mem21");
    push(K_REG, 24, 32'hFFFFFFFF, "sub_wrap_r24");
    push(K_PC, 0, 32'd14, "mix_pc");
    push(K_CYC, 0, 32'd70, "mix_cycles");
    run("mix");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_32_core.md
CPU_32_CORE -- requirements
Module: cpu_32

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning depth of unified instruction/data memory in 32-bit words (power of two).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock, and reset is synchronous and active-low.
REQ-004 The block SHALL have port halted  output  1  mirrors internal HALTED flag.
REQ-005 The block SHALL expose hierarchically accessible internals, named exactly: REG (32 x 32-bit register file), MEM (MEM_WORDS x 32-bit memory), PC (32-bit), HALTED (1-bit), state (3-bit), so benches can preload and inspect them.

Function
REQ-006 The block SHALL be a multicycle, non-pipelined 32-bit processor: one state per clock, states IF=000, ID=001, EX=010, MA=011, WB=100, HLT=101.
REQ-007 The block SHALL, in IF: IR <= MEM[PC], NPC <= PC+1 (word addressing); ID: A <= REG[IR[25:21]], B <= REG[IR[20:16]], Imm <= sign-extended IR[15:0]; EX: ALU/address/branch compute; MA: memory access, PC <= next PC; WB: register write; then return to IF.
REQ-008 The block SHALL decode opcode IR[31:26]: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 LW, 7 SW, 8 ADDI, 9 SUBI, 10 BEQZ, 11 BNEQZ, 12 SLTI, 63 HLT.
REQ-009 The block SHALL, for R-type (0-5), write REG[IR[15:11]] <= A op B; SLT is signed, result 1/0; MUL keeps low 32 bits; add/sub wrap modulo 2^32.
REQ-010 The block SHALL, for I-type ALU (8, 9, 12), write REG[IR[20:16]] <= A op Imm.
REQ-011 The block SHALL, for LW, load REG[IR[20:16]] <= MEM[A+Imm]; for SW, store MEM[A+Imm] <= B; effective address uses the low log2(MEM_WORDS) bits (wrap-around).
REQ-012 The block SHALL, for BEQZ/BNEQZ, test A==0 / A!=0; taken: PC <= NPC+Imm; not taken: PC <= NPC; no register write.
REQ-013 The block SHALL, for all non-branch instructions, set PC <= NPC.
REQ-014 The block SHALL, on HLT, set HALTED=1 at WB and enter state HLT, remaining there (no PC, REG or MEM change) until reset.
REQ-015 The block SHALL treat REG[0] as constant zero: reads return 0, writes ignored.
REQ-016 The block SHALL treat undefined opcodes as NOP (PC <= NPC, no writes).
REQ-017 The block SHALL complete every instruction in exactly 5 clocks; HLT reaches HALTED=1 on its 5th clock.

Reset
REQ-018 The block SHALL, on a rising clk edge with rst_n=0, set PC=0, HALTED=0, halted=0, state=IF, IR/A/B/Imm/NPC=0, in any state including mid-instruction; the aborted instruction SHALL perform no later writes.
REQ-019 The block SHALL NOT clear REG or MEM on reset (preloaded contents persist).
REQ-020 The block SHALL begin fetching MEM[0] on the first clock after rst_n returns to 1.

Verification
REQ-021 Preload REG[k]=k, MEM[0]=0x00222000 (ADD R4=R1+R2), MEM[1]=0xFC000000 -> after 10 clocks REG[4]=3, halted=1, PC=2.
REQ-022 Preload REG[k]=k, MEM[0]=0x04413800 (SUB R7=R2-R1), MEM[1]=0x2021FFFF (ADDI R1=R1-1), MEM[2]=HLT -> REG[7]=1, REG[1]=0.
REQ-023 Preload REG[k]=k, MEM[8]=4, MEM[0]=0x19020000 (LW R2,0(R8)), MEM[1]=0x1CA20002 (SW R2,2(R5)), MEM[2]=HLT -> REG[2]=4, MEM[7]=4.
REQ-024 MEM[0]=0x28000001 (BEQZ R0,+1), MEM[1]=0x20210005, MEM[2]=HLT -> branch taken, REG[1] unchanged, halted after 10 clocks; 0x2C200001 (BNEQZ R1,+1) with REG[1]=1 likewise skips.
REQ-025 Assert rst_n=0 for one clock during EX of an ADD to R4 -> REG[4] unchanged, PC=0, state=IF, then program re-executes from MEM[0].
REQ-026 Write to R0 (ADDI R0,R1,5 = 0x20200005) -> REG[0] reads 0; after HLT, 20 further clocks leave PC, REG, MEM unchanged.
